seq_step_counter: RTL and testbench
===================================

Name: seq_step_counter

Overview:
Programmable step sequencer for the iterative multiplier datapath. Counts a runtime-loaded number of steps, up or down, in one-shot or free-running wrap mode. Provides a start/busy/done handshake so a control FSM can launch N partial-product iterations and be told when they finish. It generalises the fixed-limit counter with a runtime modulus, direction, mode, a sync abort and a terminal pulse.

Parameters:
WIDTH, 8, bit-width of count and max_count
PRESCALE, 4, enable ticks per count step; used only when PRESCALE_EN is defined; legal range >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-high
start  input  1  launch a run; sampled only in IDLE
clear  input  1  synchronous abort to IDLE; priority over all other inputs
enable  input  1  step qualifier; the count advances only on enabled edges in RUN
max_count  input  WIDTH  terminal value; latched at start
dir  input  1  0 = up (0 to max), 1 = down (max to 0); latched at start
mode  input  1  0 = one-shot, 1 = wrap (free-running); latched at start
count  output  WIDTH  current step value, registered
busy  output  1  high while in RUN, registered
last  output  1  combinational: busy AND count == terminal value
done  output  1  one-cycle registered pulse on terminal step

Behaviour:
- Reset values: count = 0, busy = 0, done = 0, FSM = IDLE, latched max/dir/mode = 0. The async reset acts at any time, including mid-run, and produces no done pulse.
- Terminal value: max_q when dir_q = 0, and 0 when dir_q = 1. The start value is the opposite end.
- The FSM has two states, IDLE and RUN. done is a registered pulse, not a state.
- IDLE behaviour:
  - count holds its value.
  - On start with clear = 0: latch max_count, dir and mode into max_q, dir_q and mode_q. Load count with the start value, set busy = 1 and go to RUN.
  - The first step is consumed on the next enabled edge. Latency from start to busy is 1 clock.
- RUN, on an enabled edge with count != terminal: count advances by +1 (up) or -1 (down).
- RUN, on an enabled edge with count == terminal:
  - One-shot mode: count holds the terminal value, busy is set to 0, done is set to 1 and the FSM goes to IDLE.
  - Wrap mode: count reloads the start value, done is set to 1 and busy stays 1.
- RUN with enable = 0: count, busy and FSM all hold.
- done is high for exactly one cycle after each terminal edge; otherwise done = 0 every cycle.
- Step counts: a one-shot run consumes max_q + 1 enabled edges after start. With max_count = 0 the first enabled edge is already terminal.
- start while in RUN is ignored. The max_count, dir and mode inputs have no effect during RUN; only the latched copies are used.
- clear in any state: FSM goes to IDLE, count = 0, busy = 0, done = 0. clear together with start leaves the block in IDLE.
- Arithmetic is unsigned and modulo 2^WIDTH. Overflow cannot occur because the terminal is checked before each increment or decrement.
- last is valid only while busy = 1 and is forced to 0 in IDLE.

Optional Feature:
SEQ_STEP_COUNTER_PRESCALE_EN
- Defined:
  - An internal prescaler counter, ceil(log2(PRESCALE)) bits wide, counts enabled cycles in RUN.
  - A count step (advance, wrap or terminal action) occurs only on the enabled edge where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - The prescaler is cleared by reset, clear and start. It holds when enable = 0.
  - last additionally requires the prescaler to equal PRESCALE-1.
- Not defined: every enabled edge is a step, no prescaler logic is generated, and the PRESCALE parameter is ignored.

Test Plan:
- Up one-shot, WIDTH=8, max_count=5, dir=0, mode=0, enable=1, one start pulse -> count 0,1,2,3,4,5 on successive edges. The 6th enabled edge gives done=1 for one cycle and busy=0, and count holds 5.
- Down one-shot, max_count=3, dir=1 -> count 3,2,1,0, then done=1 and busy=0 after the 4th enabled edge. Changing max_count to 9 mid-run has no effect.
- Wrap mode, max_count=2, dir=0, mode=1 -> count 0,1,2,0,1,2,0 with done pulsing after each 2->0 reload and busy held at 1. clear=1 then gives count=0, busy=0, done=0 on the next edge.
- Enable gaps, max_count=4: toggle enable 1,0,0,1,... -> count changes only on enabled edges; done arrives after exactly 5 enabled edges. max_count=0 -> done after the first enabled edge.
- Assert reset asynchronously at count=3 mid-run -> count=0 and busy=0 immediately, with no done. Then start=1 with clear=1 in the same cycle -> stays in IDLE with busy=0.
- With SEQ_STEP_COUNTER_PRESCALE_EN defined and PRESCALE=4, max_count=2, enable=1 -> count steps every 4 edges, and done arrives 12 edges after the start edge.

Source files
------------

// File: rtl/seq_step_counter.sv
// Programmable up/down step sequencer with start/busy/done handshake.
// Optional prescaler: define SEQ_STEP_COUNTER_PRESCALE_EN.
module seq_step_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] max_count,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] count_n;
  logic             busy_n;
  logic             done_n;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] max_n;
  logic             dir_q;
  logic             dir_n;
  logic             mode_q;
  logic             mode_n;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] init;
  logic [WIDTH-1:0] load;
  logic             at_term;
  logic             pre_top;
  logic             step;

  // Terminal and reload ends follow the latched direction.
  assign term    = dir_q ? '0 : max_q;
  assign init    = dir_q ? max_q : '0;
  assign load    = dir ? max_count : '0;
  assign at_term = (count == term);

`ifdef SEQ_STEP_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_n;

  assign pre_top = (pre == PMAX);
  assign step    = enable & pre_top;

  // Prescaler counts enabled RUN cycles; cleared on start/clear.
  always_comb begin
    pre_n = pre;
    unique case (1'b1)
      clear: pre_n = '0;
      (!clear && state == IDLE): begin
        if (start) pre_n = '0;
      end
      (!clear && state == RUN): begin
        if (enable) pre_n = pre_top ? '0 : pre + PW'(1);
      end
      default: pre_n = pre;
    endcase
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre <= '0;
    else       pre <= pre_n;
  end
`else
  assign pre_top = 1'b1;
  assign step    = enable;
`endif

  // last is only meaningful in RUN.
  assign last = busy & at_term & pre_top;

  // Next-state, count and handshake decode.
  always_comb begin
    state_n = state;
    count_n = count;
    busy_n  = busy;
    done_n  = 1'b0;
    max_n   = max_q;
    dir_n   = dir_q;
    mode_n  = mode_q;
    unique case (1'b1)
      clear: begin
        state_n = IDLE;
        count_n = '0;
        busy_n  = 1'b0;
      end
      (!clear && state == IDLE): begin
        if (start) begin
          max_n   = max_count;
          dir_n   = dir;
          mode_n  = mode;
          count_n = load;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      (!clear && state == RUN): begin
        if (step) begin
          if (at_term) begin
            done_n = 1'b1;
            if (mode_q) begin
              count_n = init;
            end else begin
              busy_n  = 1'b0;
              state_n = IDLE;
            end
          end else if (dir_q) begin
            count_n = count - WIDTH'(1);
          end else begin
            count_n = count + WIDTH'(1);
          end
        end
      end
      default: state_n = state;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      max_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      busy   <= busy_n;
      done   <= done_n;
      max_q  <= max_n;
      dir_q  <= dir_n;
      mode_q <= mode_n;
    end
  end

endmodule

// File: tb/tb_seq_step_counter.sv
// Bench for seq_step_counter: run-progress model plus
// directed vectors with literal expectations.
module tb_seq_step_counter;

`ifdef SEQ_STEP_COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear;
  logic       enable;
  logic [7:0] max_count;
  logic       dir;
  logic       mode;
  logic [7:0] count;
  logic       busy;
  logic       last;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  seq_step_counter #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .enable    (enable),
    .max_count (max_count),
    .dir       (dir),
    .mode      (mode),
    .count     (count),
    .busy      (busy),
    .last      (last),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a run is "k steps taken so far" out of m_max,
  // with count derived from k and the latched direction.
  int         k;
  int         tick;
  logic       m_busy;
  logic       m_done;
  logic [7:0] m_max;
  logic       m_dir;
  logic       m_mode;
  logic [7:0] m_count;

  function automatic logic [7:0] pos(input int kk);
    return m_dir ? m_max - 8'(kk) : 8'(kk);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0; tick = 0; m_busy = 0; m_done = 0;
      m_max = 0; m_dir = 0; m_mode = 0; m_count = 0;
    end else begin
      m_done = 0;
      if (clear) begin
        m_busy = 0; m_count = 0; tick = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_max = max_count; m_dir = dir; m_mode = mode;
          k = 0; tick = 0; m_busy = 1;
          m_count = pos(0);
        end
      end else if (enable) begin
        tick++;
        if (tick == PS) begin
          tick = 0;
          if (k == int'(m_max)) begin
            m_done = 1;
            if (m_mode) k = 0;
            else m_busy = 0;
          end else begin
            k++;
          end
          m_count = pos(k);
        end
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(m_count));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_last", 32'(last),
        32'(m_busy && k == int'(m_max) && tick == PS - 1));
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] mx,
                        input logic d, input logic m);
    max_count = mx; dir = d; mode = m; start = 1;
    cyc();
    start = 0;
  endtask

  initial begin
    reset = 1; start = 0; clear = 0; enable = 0;
    max_count = 0; dir = 0; mode = 0;
    #12 reset = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_last", 32'(last), 0);

`ifndef SEQ_STEP_COUNTER_PRESCALE_EN
    // Up one-shot, max 5.
    enable = 1;
    launch(8'd5, 0, 0);
    chk("up_start", 32'(count), 0);
    chk("up_busy", 32'(busy), 1);
    cyc(5);
    chk("up_5", 32'(count), 5);
    chk("up_last", 32'(last), 1);
    cyc();
    chk("up_done", 32'(done), 1);
    chk("up_idle", 32'(busy), 0);
    chk("up_hold", 32'(count), 5);
    cyc();
    chk("up_pulse", 32'(done), 0);

    // Down one-shot, max 3, input changes ignored.
    launch(8'd3, 1, 0);
    chk("dn_start", 32'(count), 3);
    max_count = 8'd9;
    cyc(3);
    chk("dn_0", 32'(count), 0);
    chk("dn_busy", 32'(busy), 1);
    cyc();
    chk("dn_done", 32'(done), 1);
    chk("dn_idle", 32'(busy), 0);

    // Wrap mode, max 2.
    launch(8'd2, 0, 1);
    cyc(3);
    chk("wr_cnt", 32'(count), 0);
    chk("wr_done", 32'(done), 1);
    chk("wr_busy", 32'(busy), 1);
    start = 1;
    cyc(3);
    start = 0;
    chk("wr_cnt2", 32'(count), 0);
    chk("wr_done2", 32'(done), 1);
    clear = 1;
    cyc();
    clear = 0;
    chk("clr_cnt", 32'(count), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_done", 32'(done), 0);

    // Enable gaps, max 4.
    enable = 0;
    launch(8'd4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      enable = 1;
      cyc();
      enable = 0;
      if (i < 4) begin
        chk("gap_cnt", 32'(count), 32'(i + 1));
        chk("gap_nodone", 32'(done), 0);
      end else begin
        chk("gap_done", 32'(done), 1);
        chk("gap_idle", 32'(busy), 0);
      end
      cyc(2);
      chk("gap_held", 32'(count), 32'((i < 4) ? i + 1 : 4));
    end

    // max 0: first enabled edge is terminal.
    launch(8'd0, 0, 0);
    chk("z_last", 32'(last), 1);
    enable = 1;
    cyc();
    chk("z_done", 32'(done), 1);
    chk("z_idle", 32'(busy), 0);

    // Async reset mid-run at count 3.
    launch(8'd7, 0, 0);
    cyc(3);
    chk("ar_pre", 32'(count), 3);
    #2 reset = 1;
    #1;
    chk("ar_cnt", 32'(count), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(done), 0);
    reset = 0;
    cyc();
    chk("ar_nodone", 32'(done), 0);
    start = 1; clear = 1;
    cyc();
    start = 0; clear = 0;
    chk("sc_busy", 32'(busy), 0);
    chk("sc_cnt", 32'(count), 0);
    cyc();
    chk("sc_idle", 32'(busy), 0);
`else
    // Prescaled up one-shot, max 2.
    enable = 1;
    launch(8'd2, 0, 0);
    cyc(4);
    chk("ps_1", 32'(count), 1);
    cyc(7);
    chk("ps_2", 32'(count), 2);
    chk("ps_busy", 32'(busy), 1);
    chk("ps_last", 32'(last), 1);
    chk("ps_nodone", 32'(done), 0);
    cyc();
    chk("ps_done", 32'(done), 1);
    chk("ps_idle", 32'(busy), 0);
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
